// File: rtl/spi_serf_pkg.sv
// Shared types and constants for the SPI serf and its monarch counterpart.
package spi_serf_pkg;

  localparam int SPI_WIDTH = 16;

  // Idle pin levels; the synchronizers reset to these so reset release
  // never manufactures an edge.
  localparam logic SCLK_IDLE = 1'b1;
  localparam logic SS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } serf_state_t;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_serf_if.sv
// SPI pins plus the host-side command/response handshake of the serf.
interface spi_serf_if
  import spi_serf_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);

  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic [WIDTH-1:0] tx_data;
  logic             wrt;
  logic             clr_rdy;
  logic [WIDTH-1:0] cmd_rcvd;
  logic             cmd_rdy;
  logic             frm_err;

  modport master (
    output SS_n, SCLK, MOSI, tx_data, wrt, clr_rdy,
    input  cmd_rcvd, cmd_rdy, frm_err
  );

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, wrt, clr_rdy,
    output cmd_rcvd, cmd_rdy, frm_err
  );

endinterface

// File: rtl/spi_serf_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus one extra flop
// for rise/fall detection on the synchronized level.
module spi_serf_sync_edge
  import spi_serf_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  // Shift the pin into the chain; remember last synchronized level.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  // Chain and edge flop reset to the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = ~prev_q & sync;
  assign fall = prev_q & ~sync;

endmodule

// File: rtl/spi_serf.sv
// SPI responder: captures one WIDTH-bit command per SS_n frame and shifts
// a preloaded response out on MISO (SCLK idle high, MSB first).
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | no frame; wrt loads the response word, SS_n fall starts frame
//  ACTIVE | frame in progress; SCLK rise samples MOSI, fall shifts MISO
module spi_serf
  import spi_serf_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_serf_if.slave  bus,
  output wire        MISO
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  serf_state_t            state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   mosi_smpl_q, mosi_smpl_d;
  logic [WIDTH-1:0]       shft_reg_q, shft_reg_d;
  logic [WIDTH-1:0]       cmd_rcvd_q, cmd_rcvd_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   frm_err_q, frm_err_d;
  logic [SYNC_STAGES-1:0] mosi_chain_q, mosi_chain_d;

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;
  logic sclk_lvl_unused;
  logic mosi_sync;

  spi_serf_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (SS_N_IDLE)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.SS_n),
    .sync  (ss_sync),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_serf_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (SCLK_IDLE)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.SCLK),
    .sync  (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign mosi_sync = mosi_chain_q[SYNC_STAGES-1];

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      mosi_smpl_q  <= 1'b0;
      shft_reg_q   <= '0;
      cmd_rcvd_q   <= '0;
      cmd_rdy_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      mosi_chain_q <= {SYNC_STAGES{MOSI_IDLE}};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      mosi_smpl_q  <= mosi_smpl_d;
      shft_reg_q   <= shft_reg_d;
      cmd_rcvd_q   <= cmd_rcvd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      frm_err_q    <= frm_err_d;
      mosi_chain_q <= mosi_chain_d;
    end
  end

  // Next-state and datapath updates; SS_n rise takes priority over any
  // SCLK edge seen in the same clock.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    mosi_smpl_d  = mosi_smpl_q;
    shft_reg_d   = shft_reg_q;
    cmd_rcvd_d   = cmd_rcvd_q;
    cmd_rdy_d    = cmd_rdy_q & ~bus.clr_rdy;
    frm_err_d    = 1'b0;
    mosi_chain_d = {mosi_chain_q[SYNC_STAGES-2:0], bus.MOSI};

    unique case (state_q)
      IDLE: begin
        if (bus.wrt) shft_reg_d = bus.tx_data;
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          cmd_rdy_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          // The last bit never sees a fall, so it is merged in here.
          if (bit_cnt_q == CNT_FULL) begin
            cmd_rcvd_d = {shft_reg_q[WIDTH-2:0], mosi_smpl_q};
            cmd_rdy_d  = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          mosi_smpl_d = mosi_sync;
          if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL)) begin
          // Leading fall (count 0) is skipped: the MSB is already on MISO.
          shft_reg_d = {shft_reg_q[WIDTH-2:0], mosi_smpl_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Host-side outputs straight from their flops.
  always_comb begin
    bus.cmd_rcvd = cmd_rcvd_q;
    bus.cmd_rdy  = cmd_rdy_q;
    bus.frm_err  = frm_err_q;
  end

  // MISO is released whenever the synchronized select is inactive.
  assign MISO = (ss_sync == 1'b0) ? shft_reg_q[WIDTH-1] : 1'bz;

endmodule
